lmc_r50: RTL and testbench
==========================

Name: lmc_r50

Overview:
- Minimal Little-Man-Computer datapath stage: a 4-word × 8-bit program RAM addressed by a free-running 2-bit program counter, a 2:1 operand mux and a 4-bit accumulator.
- Operators load RAM manually via data_in/RAM_button.
- With the button released, the block steps through RAM one word per clock, executing load-immediate or add-immediate into the accumulator.
- Top-level of the R50 board build; outputs drive indicator LEDs.

Parameters:
- ADDR_WIDTH, 2, program-counter/RAM address width; RAM depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word width; accumulator/mux width = DATA_WIDTH/2 (4).

Ports:
- timer555  input  1  system clock, rising-edge active.
- reset_count  input  1  reset, asynchronous, active-low.
- counter  output  ADDR_WIDTH  program counter, also the RAM address.
- RAM_button  input  1  write enable: 1 = program mode (write), 0 = run mode.
- data_in  input  DATA_WIDTH  word to write into RAM.
- RAM_out  output  DATA_WIDTH  RAM[counter], combinational read.
- mux_switch_out  output  1  operand-mux select, equals RAM_out[4].
- mux_out  output  4  mux result, next accumulator value.
- Acc_out  output  4  accumulator register.

Behaviour:
- Reset (reset_count=0, asynchronous, dominates everything): counter=0, Acc_out=0, all RAM words=0. Consequently RAM_out=0x00, mux_switch_out=0, mux_out=0.
- All state changes on rising edge of timer555 while reset_count=1. No other clocks or edges are used.
- Instruction fields of RAM_out:
  - [3:0] = immediate operand.
  - [4] = op select (0 load, 1 add).
  - [7:5] reserved, ignored.
- Combinational path:
  - RAM_out = RAM[counter].
  - mux_switch_out = RAM_out[4].
  - mux_out = RAM_out[3:0] when select=0.
  - mux_out = (Acc_out + RAM_out[3:0]) mod 16 when select=1; carry discarded.
- Program mode (RAM_button=1 at the edge):
  - RAM[counter] <= data_in.
  - counter holds.
  - Acc_out holds.
  - RAM_out reflects the new word immediately after the edge.
- Run mode (RAM_button=0 at the edge):
  - counter <= counter+1, wrapping 3→0.
  - Acc_out <= mux_out, computed from the pre-edge counter/RAM/Acc.
  - RAM unchanged.
- RAM_button and data_in are sampled only at clock edges; they must be stable for ≥1 full clock period. A pulse that spans no rising edge has no effect.
- Latency: one edge from instruction presented to accumulator update; write visible on RAM_out zero cycles after the writing edge.
- Reset asserted mid-run clears counter, Acc and RAM at once. Program contents are lost and must be reloaded.
- Reset release: first rising edge with reset_count=1 acts normally per RAM_button.

Test Plan:
- Reset: reset_count=0 with arbitrary inputs -> counter=0, RAM_out=0x00, mux_switch_out=0, mux_out=0, Acc_out=0, asynchronously without a clock edge.
- Write/hold: reset_count=1, RAM_button=1, data_in=0x65 across one edge -> RAM_out=0x65, counter=0, Acc_out=0, mux_switch_out=0, mux_out=0x5.
- Load execute: from previous state, RAM_button=0, one edge -> Acc_out=0x5, counter=1, RAM_out=0x00.
- Add execute:
  - Write RAM[1]=0x13 with RAM_button=1.
  - Hold RAM[1]: mux_switch_out=1, mux_out=0x8.
  - Release button, one edge -> Acc_out=0x8, counter=2.
- Wrap/overflow:
  - Acc=0xF, RAM[2]=0x11, edge -> Acc_out=0x0, counter=3.
  - Next edge -> counter=0.
- Short pulse/reset mid-run:
  - RAM_button high 5 ns between edges -> RAM unchanged.
  - reset_count pulsed low mid-cycle -> all outputs 0 before next edge.

Source files
------------

// File: rtl/lmc_r50.sv
// -----------------------------------------------------------------------------
// lmc_r50 -- minimal Little-Man-Computer datapath stage (R50 board top level)
//
// A small program RAM is addressed by a free-running program counter. Each
// word holds an instruction:
//   [3:0]  immediate operand
//   [4]    operation: 0 = load immediate, 1 = add immediate
//   [7:5]  reserved, ignored
//
// With RAM_button held, each clock writes data_in into RAM[counter] while the
// counter and accumulator stay put. With RAM_button released, each clock
// executes RAM[counter] into the accumulator and advances the counter.
//
// Ports:
//   timer555        in   system clock, rising edge active
//   reset_count     in   asynchronous active-low reset (clears RAM too)
//   counter         out  program counter / RAM address
//   RAM_button      in   1 = program (write) mode, 0 = run mode
//   data_in         in   word written into RAM in program mode
//   RAM_out         out  RAM[counter], combinational read
//   mux_switch_out  out  operand-mux select (RAM_out op bit)
//   mux_out         out  next accumulator value
//   Acc_out         out  accumulator register
// -----------------------------------------------------------------------------
module lmc_r50 #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  timer555,
  input  logic                  reset_count,
  output logic [ADDR_WIDTH-1:0] counter,
  input  logic                  RAM_button,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] RAM_out,
  output logic                  mux_switch_out,
  output logic [3:0]            mux_out,
  output logic [3:0]            Acc_out
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int ACC_WIDTH = DATA_WIDTH / 2;
  // The op-select bit sits directly above the immediate field.
  localparam int OP_BIT    = ACC_WIDTH;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_ADD  = 1'b1
  } op_e;

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [ACC_WIDTH-1:0]  imm;
  op_e                   op;

  // ---------------------------------------------------------------------------
  // Program RAM. The board expects a reset to wipe the program, so the words
  // are flops with an asynchronous clear rather than an inferred RAM macro.
  // ---------------------------------------------------------------------------
  always_ff @(posedge timer555 or negedge reset_count) begin
    if (!reset_count) begin
      // NOTE: memories are not normally reset; here it is a functional
      // requirement (reset must erase the program), so every word is cleared.
      for (int i = 0; i < DEPTH; i++) begin
        ram[i] <= '0;
      end
    end else if (RAM_button) begin
      // NOTE: non-blocking assignments for all registered state, so every
      // flop in this block samples pre-edge values regardless of order.
      ram[counter] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Program counter and accumulator: both hold in program mode and advance
  // together in run mode. The counter wraps naturally at DEPTH.
  // ---------------------------------------------------------------------------
  always_ff @(posedge timer555 or negedge reset_count) begin
    if (!reset_count) begin
      counter <= '0;
      acc     <= '0;
    end else if (!RAM_button) begin
      counter <= counter + ADDR_WIDTH'(1);
      acc     <= acc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read and execute path.
  // ---------------------------------------------------------------------------
  assign RAM_out = ram[counter];
  assign imm     = RAM_out[ACC_WIDTH-1:0];
  assign op      = op_e'(RAM_out[OP_BIT]);

  always_comb begin
    // NOTE: default first so every path assigns acc_next and no latch forms.
    acc_next = imm;
    case (op)
      OP_LOAD: acc_next = imm;
      // Sum is truncated to the accumulator width; the carry is dropped.
      OP_ADD:  acc_next = acc + imm;
      default: acc_next = imm;
    endcase
  end

  assign mux_switch_out = RAM_out[OP_BIT];
  assign mux_out        = acc_next;
  assign Acc_out        = acc;

endmodule

// File: tb/tb_lmc_r50.sv
// -----------------------------------------------------------------------------
// Self-checking bench for lmc_r50. A table of per-edge vectors drives the
// program/run sequence; each expected record is queued when its stimulus is
// driven and popped for comparison once the edge has happened. Hand-written
// sequences cover asynchronous reset, a button pulse between edges and reset
// asserted mid-cycle.
// -----------------------------------------------------------------------------
module tb_lmc_r50;

  logic       timer555;
  logic       reset_count;
  logic [1:0] counter;
  logic       RAM_button;
  logic [7:0] data_in;
  logic [7:0] RAM_out;
  logic       mux_switch_out;
  logic [3:0] mux_out;
  logic [3:0] Acc_out;

  lmc_r50 #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .timer555       (timer555),
    .reset_count    (reset_count),
    .counter        (counter),
    .RAM_button     (RAM_button),
    .data_in        (data_in),
    .RAM_out        (RAM_out),
    .mux_switch_out (mux_switch_out),
    .mux_out        (mux_out),
    .Acc_out        (Acc_out)
  );

  initial timer555 = 1'b0;
  always #5 timer555 = ~timer555;

  typedef struct {
    logic       btn;
    logic [7:0] din;
    logic [1:0] cnt;
    logic [7:0] ram;
    logic       sel;
    logic [3:0] mux;
    logic [3:0] acc;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];
  vec_t sb_q [$];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] cnt, input logic [7:0] ram,
                           input logic sel, input logic [3:0] mux, input logic [3:0] acc);
    check({tag, ".counter"}, 32'(counter), 32'(cnt));
    check({tag, ".RAM_out"}, 32'(RAM_out), 32'(ram));
    check({tag, ".mux_switch_out"}, 32'(mux_switch_out), 32'(sel));
    check({tag, ".mux_out"}, 32'(mux_out), 32'(mux));
    check({tag, ".Acc_out"}, 32'(Acc_out), 32'(acc));
  endtask

  initial begin
    vec_t e;

    //          btn   din     cnt   ram     sel   mux    acc
    vecs[0]  = '{1'b1, 8'h65, 2'd0, 8'h65, 1'b0, 4'h5, 4'h0}; // write RAM[0]
    vecs[1]  = '{1'b0, 8'h00, 2'd1, 8'h00, 1'b0, 4'h0, 4'h5}; // load 5
    vecs[2]  = '{1'b1, 8'h13, 2'd1, 8'h13, 1'b1, 4'h8, 4'h5}; // write add 3
    vecs[3]  = '{1'b0, 8'h00, 2'd2, 8'h00, 1'b0, 4'h0, 4'h8}; // 5+3
    vecs[4]  = '{1'b1, 8'h11, 2'd2, 8'h11, 1'b1, 4'h9, 4'h8}; // write add 1
    vecs[5]  = '{1'b0, 8'h00, 2'd3, 8'h00, 1'b0, 4'h0, 4'h9};
    vecs[6]  = '{1'b1, 8'h0F, 2'd3, 8'h0F, 1'b0, 4'hF, 4'h9}; // write load F
    vecs[7]  = '{1'b0, 8'h00, 2'd0, 8'h65, 1'b0, 4'h5, 4'hF}; // wrap 3->0
    vecs[8]  = '{1'b1, 8'h10, 2'd0, 8'h10, 1'b1, 4'hF, 4'hF}; // rewrite add 0
    vecs[9]  = '{1'b0, 8'h00, 2'd1, 8'h13, 1'b1, 4'h2, 4'hF};
    vecs[10] = '{1'b1, 8'h10, 2'd1, 8'h10, 1'b1, 4'hF, 4'hF}; // rewrite add 0
    vecs[11] = '{1'b0, 8'h00, 2'd2, 8'h11, 1'b1, 4'h0, 4'hF}; // F+1 overflows
    vecs[12] = '{1'b0, 8'h00, 2'd3, 8'h0F, 1'b0, 4'hF, 4'h0}; // acc wrapped to 0
    vecs[13] = '{1'b0, 8'h00, 2'd0, 8'h10, 1'b1, 4'hF, 4'hF}; // counter wraps
    vecs[14] = '{1'b1, 8'hE4, 2'd0, 8'hE4, 1'b0, 4'h4, 4'hF}; // reserved bits set
    vecs[15] = '{1'b0, 8'h00, 2'd1, 8'h10, 1'b1, 4'h4, 4'h4}; // reserved ignored

    // Reset with arbitrary inputs, checked before the first clock edge.
    reset_count = 1'b0;
    RAM_button  = 1'b1;
    data_in     = 8'hAA;
    #1;
    check_all("reset_async", 2'd0, 8'h00, 1'b0, 4'h0, 4'h0);

    // Reset must dominate a held write across clock edges.
    repeat (2) @(posedge timer555);
    #1;
    check_all("reset_hold", 2'd0, 8'h00, 1'b0, 4'h0, 4'h0);

    @(negedge timer555);
    reset_count = 1'b1;

    // Table-driven program/run sequence with queued expectations.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge timer555);
      RAM_button = vecs[i].btn;
      data_in    = vecs[i].din;
      sb_q.push_back(vecs[i]);
      @(posedge timer555);
      #1;
      if (sb_q.size() == 0) begin
        check($sformatf("vec%0d.scoreboard_empty", i), 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_all($sformatf("vec%0d", i), e.cnt, e.ram, e.sel, e.mux, e.acc);
      end
    end

    // Button pulse that spans no rising edge: RAM[1] must keep 0x10.
    RAM_button = 1'b0;
    data_in    = 8'h00;
    #1;
    RAM_button = 1'b1;
    data_in    = 8'hFF;
    #5;
    RAM_button = 1'b0;
    data_in    = 8'h00;
    check("pulse.RAM_out", 32'(RAM_out), 32'h10);
    check("pulse.counter", 32'(counter), 32'd1);
    @(posedge timer555);
    #1;
    check_all("pulse_run", 2'd2, 8'h11, 1'b1, 4'h5, 4'h4);

    // Reset pulsed low mid-cycle clears everything without an edge.
    #1;
    reset_count = 1'b0;
    #1;
    check_all("reset_mid", 2'd0, 8'h00, 1'b0, 4'h0, 4'h0);
    #2;
    reset_count = 1'b1;
    #1;
    check_all("reset_mid_release", 2'd0, 8'h00, 1'b0, 4'h0, 4'h0);

    // First edge after release behaves normally (write), then a run step.
    RAM_button = 1'b1;
    data_in    = 8'h1F;
    @(posedge timer555);
    #1;
    check_all("post_reset_write", 2'd0, 8'h1F, 1'b1, 4'hF, 4'h0);
    @(negedge timer555);
    RAM_button = 1'b0;
    @(posedge timer555);
    #1;
    check_all("post_reset_run", 2'd1, 8'h00, 1'b0, 4'h0, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
